// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator scheduler slice.
// State codes, status one-hot patterns, direction flags and default timings.
package elevator_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;
  localparam logic [1:0] ST_DOOR = 2'd3;

  localparam logic [3:0] STS_IDLE  = 4'b0001;
  localparam logic [3:0] STS_UP    = 4'b0010;
  localparam logic [3:0] STS_DOWN  = 4'b0100;
  localparam logic [3:0] STS_DOOR  = 4'b1000;
  localparam logic [3:0] STS_ESTOP = 4'b1001;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int DEF_MOVE_TICKS = 3;
  localparam int DEF_DOOR_TICKS = 5;

  function automatic logic [3:0] st_to_status(
    input logic [1:0] s
  );
    logic [3:0] v;
    v = STS_IDLE;
    unique case (s)
      ST_IDLE: v = STS_IDLE;
      ST_UP:   v = STS_UP;
      ST_DOWN: v = STS_DOWN;
      ST_DOOR: v = STS_DOOR;
      default: v = STS_IDLE;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/elevator_req_reg.sv
// Pending-call bitmap with clear-over-set priority and
// above/below reductions relative to an evaluation floor.
module elevator_req_reg
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 8
) (
  input  logic       i_ck,
  input  logic       i_rst,
  input  logic [7:0] i_req,
  input  logic [7:0] i_clr,
  input  logic [7:0] i_hold,
  input  logic [3:0] i_floor,
  output logic [7:0] o_pending,
  output logic       o_here,
  output logic       o_above,
  output logic       o_below
);

  localparam logic [7:0] MASK = 8'((1 << NUM_FLOORS) - 1);

  logic [7:0] r_pend;
  logic [7:0] w_above;
  logic [7:0] w_below;
  logic [7:0] w_sel;

  always_ff @(posedge i_ck or posedge i_rst) begin
    if (i_rst)
      r_pend <= '0;
    else
      r_pend <= (r_pend | (i_req & MASK & ~i_hold)) & ~i_clr;
  end

  assign w_sel   = 8'd1 << i_floor;
  assign w_above = 8'hFF << ({1'b0, i_floor} + 5'd1);
  assign w_below = ~(8'hFF << i_floor);

  assign o_pending = r_pend;
  assign o_here    = |(r_pend & w_sel);
  assign o_above   = |(r_pend & w_above);
  assign o_below   = |(r_pend & w_below);

endmodule

// File: rtl/elevator_scheduler.sv
// Single-car SCAN elevator sequencer with tick-based travel/door timers.
// Optional ELEVATOR_ESTOP_EN adds an estop input that freezes the car.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 8,
  parameter int MOVE_TICKS = DEF_MOVE_TICKS,
  parameter int DOOR_TICKS = DEF_DOOR_TICKS
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       tick,
`ifdef ELEVATOR_ESTOP_EN
  input  logic       estop,
`endif
  input  logic [7:0] req_btn,
  output logic [3:0] floor,
  output logic [3:0] countdown,
  output logic [7:0] floor_btn,
  output logic [3:0] status
);

  localparam logic [3:0] MT  = 4'(MOVE_TICKS);
  localparam logic [3:0] DT  = 4'(DOOR_TICKS);
  localparam logic [3:0] TOP = 4'(NUM_FLOORS - 1);

  logic [1:0] r_state;
  logic       r_dir;
  logic [3:0] r_floor;
  logic [3:0] r_cnt;
  logic       r_estop;

  logic [1:0] w_state;
  logic       w_dir;
  logic [3:0] w_floor;
  logic [3:0] w_cnt;
  logic [7:0] w_clr;
  logic [7:0] w_hold;
  logic       w_run;
  logic       w_moving;
  logic       w_arrive;
  logic [3:0] w_step;
  logic [3:0] w_eval;
  logic       w_here;
  logic       w_above;
  logic       w_below;
  logic       w_ahead;
  logic       w_behind;
  logic       w_door_hold;
  logic       w_decide;
  logic       w_allow;

`ifdef ELEVATOR_ESTOP_EN
  assign w_run = ~estop;
`else
  assign w_run = 1'b1;
`endif

  assign w_moving = (r_state == ST_UP) || (r_state == ST_DOWN);
  assign w_arrive = w_run && tick && w_moving && (r_cnt == 4'd1);

  // Clamp at the shaft ends; the arrival decision then reverses.
  always_comb begin
    w_step = r_floor;
    if (r_state == ST_UP && r_floor != TOP)
      w_step = r_floor + 4'd1;
    else if (r_state == ST_DOWN && r_floor != 4'd0)
      w_step = r_floor - 4'd1;
  end

  assign w_eval   = w_arrive ? w_step : r_floor;
  assign w_ahead  = (r_dir == DIR_UP) ? w_above : w_below;
  assign w_behind = (r_dir == DIR_UP) ? w_below : w_above;

  assign w_hold = (r_state == ST_DOOR) ? (8'd1 << r_floor) : 8'd0;
  assign w_door_hold = |(req_btn & w_hold);

  elevator_req_reg #(
    .NUM_FLOORS (NUM_FLOORS)
  ) u_req (
    .i_ck      (ck),
    .i_rst     (rst),
    .i_req     (req_btn),
    .i_clr     (w_clr),
    .i_hold    (w_hold),
    .i_floor   (w_eval),
    .o_pending (floor_btn),
    .o_here    (w_here),
    .o_above   (w_above),
    .o_below   (w_below)
  );

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_UP;
      r_floor <= '0;
      r_cnt   <= '0;
      r_estop <= 1'b0;
    end else begin
      r_state <= w_state;
      r_dir   <= w_dir;
      r_floor <= w_floor;
      r_cnt   <= w_cnt;
      r_estop <= ~w_run;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_dir    = r_dir;
    w_floor  = r_floor;
    w_cnt    = r_cnt;
    w_clr    = '0;
    w_decide = 1'b0;
    w_allow  = 1'b0;
    if (w_run) begin
      unique case (r_state)
        ST_IDLE: begin
          w_decide = 1'b1;
          w_allow  = 1'b1;
        end
        ST_UP, ST_DOWN: begin
          if (tick) begin
            w_cnt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              w_floor  = w_step;
              w_decide = 1'b1;
              w_allow  = 1'b1;
            end
          end
        end
        ST_DOOR: begin
          if (w_door_hold)
            w_cnt = DT;
          else if (tick) begin
            w_cnt = r_cnt - 4'd1;
            w_decide = (r_cnt == 4'd1);
          end
        end
        default: ;
      endcase
      if (w_decide) begin
        if (w_allow && w_here) begin
          w_state = ST_DOOR;
          w_cnt   = DT;
          w_clr   = 8'd1 << w_eval;
        end else if (w_ahead) begin
          w_state = (r_dir == DIR_UP) ? ST_UP : ST_DOWN;
          w_cnt   = MT;
        end else if (w_behind) begin
          w_dir   = ~r_dir;
          w_state = (r_dir == DIR_UP) ? ST_DOWN : ST_UP;
          w_cnt   = MT;
        end else begin
          w_state = ST_IDLE;
          w_cnt   = '0;
        end
      end
    end
  end

  always_comb begin
    status = st_to_status(r_state);
    if (r_estop)
      status = status | STS_ESTOP;
  end

  assign floor     = r_floor;
  assign countdown = r_cnt;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed vector bench for elevator_scheduler (default timings 3/5, 8 floors).
// Inputs change on the falling edge; outputs are compared on the next falling edge.
module tb_elevator_scheduler;

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] req_btn = '0;
  logic [3:0] floor;
  logic [3:0] countdown;
  logic [7:0] floor_btn;
  logic [3:0] status;
`ifdef ELEVATOR_ESTOP_EN
  logic       estop = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 ck = ~ck;

  elevator_scheduler dut (
    .ck        (ck),
    .rst       (rst),
    .tick      (tick),
`ifdef ELEVATOR_ESTOP_EN
    .estop     (estop),
`endif
    .req_btn   (req_btn),
    .floor     (floor),
    .countdown (countdown),
    .floor_btn (floor_btn),
    .status    (status)
  );

  typedef struct {
    logic       rs;
    logic [7:0] req;
    logic       tk;
    logic [3:0] fl;
    logic [3:0] cd;
    logic [7:0] btn;
    logic [3:0] st;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic rs, input logic [7:0] req, input logic tk,
    input logic [3:0] fl, input logic [3:0] cd,
    input logic [7:0] btn, input logic [3:0] st
  );
    vec_t v;
    v.rs = rs; v.req = req; v.tk = tk;
    v.fl = fl; v.cd = cd; v.btn = btn; v.st = st;
    return v;
  endfunction

  task automatic chk(
    input string nm, input logic [7:0] act, input logic [7:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(
    input string nm, input logic [3:0] fl, input logic [3:0] cd,
    input logic [7:0] btn, input logic [3:0] st
  );
    chk({nm, ".floor"}, {4'd0, floor}, {4'd0, fl});
    chk({nm, ".countdown"}, {4'd0, countdown}, {4'd0, cd});
    chk({nm, ".floor_btn"}, floor_btn, btn);
    chk({nm, ".status"}, {4'd0, status}, {4'd0, st});
  endtask

  task automatic cyc(input logic [7:0] r, input logic t);
    req_btn = r;
    tick    = t;
    @(negedge ck);
    req_btn = '0;
    tick    = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(8'h00, 1'b1);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cyc(8'h00, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    // Call to floor 2 from idle at floor 0, then door dwell and back to idle.
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 4'b0001));
    vq.push_back(mk(0, 8'h04, 0, 0, 0, 8'h04, 4'b0001));
    vq.push_back(mk(0, 8'h00, 0, 0, 3, 8'h04, 4'b0010));
    vq.push_back(mk(0, 8'h00, 1, 0, 2, 8'h04, 4'b0010));
    vq.push_back(mk(0, 8'h00, 1, 0, 1, 8'h04, 4'b0010));
    vq.push_back(mk(0, 8'h00, 1, 1, 3, 8'h04, 4'b0010));
    vq.push_back(mk(0, 8'h00, 1, 1, 2, 8'h04, 4'b0010));
    vq.push_back(mk(0, 8'h00, 1, 1, 1, 8'h04, 4'b0010));
    vq.push_back(mk(0, 8'h00, 1, 2, 5, 8'h00, 4'b1000));
    vq.push_back(mk(0, 8'h00, 1, 2, 4, 8'h00, 4'b1000));
    vq.push_back(mk(0, 8'h00, 1, 2, 3, 8'h00, 4'b1000));
    vq.push_back(mk(0, 8'h00, 1, 2, 2, 8'h00, 4'b1000));
    vq.push_back(mk(0, 8'h00, 1, 2, 1, 8'h00, 4'b1000));
    vq.push_back(mk(0, 8'h00, 1, 2, 0, 8'h00, 4'b0001));
    // Reset, call 5, then 2 pressed in flight: 2 is served first.
    vq.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 4'b0001));
    vq.push_back(mk(0, 8'h20, 0, 0, 0, 8'h20, 4'b0001));
    vq.push_back(mk(0, 8'h00, 0, 0, 3, 8'h20, 4'b0010));
    vq.push_back(mk(0, 8'h04, 1, 0, 2, 8'h24, 4'b0010));
    vq.push_back(mk(0, 8'h00, 1, 0, 1, 8'h24, 4'b0010));
    vq.push_back(mk(0, 8'h00, 1, 1, 3, 8'h24, 4'b0010));
    vq.push_back(mk(0, 8'h00, 1, 1, 2, 8'h24, 4'b0010));
    vq.push_back(mk(0, 8'h00, 1, 1, 1, 8'h24, 4'b0010));
    vq.push_back(mk(0, 8'h00, 1, 2, 5, 8'h20, 4'b1000));
    vq.push_back(mk(0, 8'h00, 1, 2, 4, 8'h20, 4'b1000));
    vq.push_back(mk(0, 8'h00, 1, 2, 3, 8'h20, 4'b1000));
    vq.push_back(mk(0, 8'h00, 1, 2, 2, 8'h20, 4'b1000));
    vq.push_back(mk(0, 8'h00, 1, 2, 1, 8'h20, 4'b1000));
    vq.push_back(mk(0, 8'h00, 1, 2, 3, 8'h20, 4'b0010));

    repeat (2) @(negedge ck);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rs;
      cyc(vq[i].req, vq[i].tk);
      rst = 1'b0;
      chk_all($sformatf("vec%0d", i),
              vq[i].fl, vq[i].cd, vq[i].btn, vq[i].st);
    end

    ticks(9);
    chk_all("serve5", 4'd5, 4'd5, 8'h00, 4'b1000);

    // Moving up toward 6, call 1 from floor 4: 6 first, then reverse.
    do_reset();
    cyc(8'h40, 1'b0);
    cyc(8'h00, 1'b0);
    ticks(12);
    chk_all("at4", 4'd4, 4'd3, 8'h40, 4'b0010);
    cyc(8'h02, 1'b0);
    chk("press1.btn", floor_btn, 8'h42);
    ticks(6);
    chk_all("door6", 4'd6, 4'd5, 8'h02, 4'b1000);
    ticks(5);
    chk_all("rev6", 4'd6, 4'd3, 8'h02, 4'b0100);
    ticks(15);
    chk_all("door1", 4'd1, 4'd5, 8'h00, 4'b1000);

    // Door hold at floor 3 with countdown 1.
    do_reset();
    cyc(8'h08, 1'b0);
    cyc(8'h00, 1'b0);
    ticks(13);
    chk_all("door3cd1", 4'd3, 4'd1, 8'h00, 4'b1000);
    cyc(8'h08, 1'b0);
    chk_all("hold3", 4'd3, 4'd5, 8'h00, 4'b1000);
    ticks(5);
    chk_all("idle3", 4'd3, 4'd0, 8'h00, 4'b0001);

    // Call at the current floor while idle.
    do_reset();
    cyc(8'h01, 1'b0);
    chk_all("latch0", 4'd0, 4'd0, 8'h01, 4'b0001);
    cyc(8'h00, 1'b0);
    chk_all("door0", 4'd0, 4'd5, 8'h00, 4'b1000);

    // Asynchronous reset in the middle of a move.
    do_reset();
    cyc(8'h20, 1'b0);
    cyc(8'h00, 1'b0);
    ticks(10);
    chk_all("mid3", 4'd3, 4'd2, 8'h20, 4'b0010);
    rst = 1'b1;
    #1;
    chk_all("async_rst", 4'd0, 4'd0, 8'h00, 4'b0001);
    @(negedge ck);
    rst = 1'b0;

`ifdef ELEVATOR_ESTOP_EN
    do_reset();
    cyc(8'h20, 1'b0);
    cyc(8'h00, 1'b0);
    ticks(1);
    estop = 1'b1;
    cyc(8'h04, 1'b1);
    ticks(10);
    chk_all("estop", 4'd0, 4'd2, 8'h24, 4'b1011);
    estop = 1'b0;
    cyc(8'h00, 1'b0);
    chk_all("release", 4'd0, 4'd2, 8'h24, 4'b0010);
    ticks(2);
    chk_all("resume", 4'd1, 4'd3, 8'h24, 4'b0010);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
